cache_ctrl_fsm: RTL

CACHE_CTRL_FSM -- requirements
Module: cache_ctrl_fsm

---
 rtl/cache_ctrl_pkg.sv | 18 +
 rtl/cache_ctrl_fsm_lru_tracker.sv | 65 ++++++
 rtl/cache_ctrl_fsm.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache controller: FSM state encoding and
// write-policy constants used by the WRITE_BACK parameter.
package cache_ctrl_pkg;

  localparam int WB_POLICY_WRITE_THROUGH = 0;  // write-through, no write-allocate
  localparam int WB_POLICY_WRITE_BACK    = 1;  // write-back, write-allocate

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_REFILL    = 3'd3,
    ST_MEMWRITE  = 3'd4,
    ST_UPDATE    = 3'd5,
    ST_RESPOND   = 3'd6
  } state_e;

endpackage

// File: rtl/cache_ctrl_fsm_lru_tracker.sv
// True-LRU bookkeeping for every set. Each set stores an ordered list of way
// numbers: position 0 holds the LRU way, position WAYS-1 the MRU way.
// Touching a way removes it from the list and re-inserts it at the MRU end.
// Storage is kept in flops because reset must initialise every set at once.
module lru_tracker #(
  parameter int WAYS = 4,
  parameter int SETS = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [$clog2(SETS)-1:0]  rd_set,
  output logic [$clog2(WAYS)-1:0]  victim,
  input  logic                     touch_en,
  input  logic [$clog2(WAYS)-1:0]  touch_way
);

  localparam int WW = $clog2(WAYS);

  logic [WW-1:0] order_q [SETS][WAYS];
  logic [WW-1:0] row_cur [WAYS];
  logic [WW-1:0] row_d   [WAYS];
  logic          found;

  // Read the ordering of the selected set; its first entry is the victim.
  always_comb begin
    for (int p = 0; p < WAYS; p++) begin
      row_cur[p] = order_q[rd_set][p];
    end
    victim = order_q[rd_set][0];
  end

  // Build the post-touch ordering: entries above the touched way slide down
  // one position and the touched way lands in the MRU slot.
  always_comb begin
    found = 1'b0;
    for (int p = 0; p < WAYS; p++) begin
      row_d[p] = row_cur[p];
    end
    for (int p = 0; p < WAYS - 1; p++) begin
      if (row_cur[p] == touch_way) begin
        found = 1'b1;
      end
      if (found) begin
        row_d[p] = row_cur[p + 1];
      end
    end
    row_d[WAYS-1] = touch_way;
  end

  // Reset puts way 0 at LRU and way WAYS-1 at MRU; a touch rewrites one set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int p = 0; p < WAYS; p++) begin
          order_q[s][p] <= WW'(p);
        end
      end
    end else if (touch_en) begin
      for (int p = 0; p < WAYS; p++) begin
        order_q[rd_set][p] <= row_d[p];
      end
    end
  end

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Cache controller FSM: accepts one CPU request at a time, looks up the tag
// result, performs write-back / refill / write-through traffic to memory,
// drives the one-hot array write enables and reports completion. LRU order
// is maintained by lru_tracker and updated when a request responds.
module cache_ctrl_fsm
  import cache_ctrl_pkg::*;
#(
  parameter int WAYS       = 4,
  parameter int SETS       = 64,
  parameter int WRITE_BACK = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [$clog2(SETS)-1:0]  req_set,
  input  logic                     hit,
  input  logic [$clog2(WAYS)-1:0]  hit_way,
  input  logic                     victim_dirty,
  output logic [$clog2(WAYS)-1:0]  victim_way,
  output logic                     mem_rd_req,
  output logic                     mem_wr_req,
  input  logic                     mem_ack,
  output logic [WAYS-1:0]          way_we,
  output logic                     fill_sel,
  output logic                     resp_valid,
  output logic                     resp_hit
);

  localparam int              SW     = $clog2(SETS);
  localparam int              WW     = $clog2(WAYS);
  localparam bit              WB_EN  = (WRITE_BACK == WB_POLICY_WRITE_BACK);
  localparam logic [WAYS-1:0] WAY0   = WAYS'(1);

  state_e        state_q, state_d;
  logic          write_q, write_d;
  logic [SW-1:0] set_q, set_d;
  logic          hit_q, hit_d;
  logic [WW-1:0] hit_way_q, hit_way_d;
  logic          touch_en;
  logic [WW-1:0] touch_way;
  logic [WW-1:0] target_way;

  lru_tracker #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_set    (set_q),
    .victim    (victim_way),
    .touch_en  (touch_en),
    .touch_way (touch_way)
  );

  // The way that receives the CPU data or becomes MRU: hit way or the victim.
  assign target_way = hit_q ? hit_way_q : victim_way;

  // State and latched-request registers; reset aborts any operation at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      write_q   <= 1'b0;
      set_q     <= '0;
      hit_q     <= 1'b0;
      hit_way_q <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      set_q     <= set_d;
      hit_q     <= hit_d;
      hit_way_q <= hit_way_d;
    end
  end

  // Next-state and output decode; tag results are sampled only in LOOKUP.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    set_d      = set_q;
    hit_d      = hit_q;
    hit_way_d  = hit_way_q;
    req_ready  = 1'b0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    way_we     = '0;
    fill_sel   = 1'b0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    touch_en   = 1'b0;
    touch_way  = target_way;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          set_d   = req_set;
          state_d = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        hit_d     = hit;
        hit_way_d = hit_way;
        if (hit) begin
          if (!write_q)   state_d = ST_RESPOND;
          else if (WB_EN) state_d = ST_UPDATE;
          else            state_d = ST_MEMWRITE;
        end else begin
          if (write_q && !WB_EN)       state_d = ST_MEMWRITE;  // no allocate
          else if (WB_EN && victim_dirty) state_d = ST_WRITEBACK;
          else                         state_d = ST_REFILL;
        end
      end

      ST_WRITEBACK: begin
        mem_wr_req = 1'b1;
        if (mem_ack) state_d = ST_REFILL;
      end

      ST_REFILL: begin
        mem_rd_req = 1'b1;
        if (mem_ack) begin
          way_we   = WAY0 << victim_way;
          fill_sel = 1'b0;
          state_d  = write_q ? ST_UPDATE : ST_RESPOND;
        end
      end

      ST_MEMWRITE: begin
        mem_wr_req = 1'b1;
        if (mem_ack) state_d = hit_q ? ST_UPDATE : ST_RESPOND;
      end

      ST_UPDATE: begin
        way_we   = WAY0 << target_way;
        fill_sel = 1'b1;
        state_d  = ST_RESPOND;
      end

      ST_RESPOND: begin
        resp_valid = 1'b1;
        resp_hit   = hit_q;
        // A write-through miss never allocated a line, so LRU stays put.
        touch_en   = !(!WB_EN && write_q && !hit_q);
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
